z80_wait_gen: RTL and testbench



---
 rtl/msx_bus_pkg.sv | 23 ++
 rtl/wait_down_counter.sv | 47 ++++
 rtl/z80_wait_gen.sv | 131 +++++++++++++
 tb/tb_z80_wait_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/msx_bus_pkg.sv
// ============================================================================
// Package : msx_bus_pkg
// Shared MSX bus types and defaults for the Z80 wait-state generator.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package msx_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } wait_state_e;

    localparam int unsigned WAIT_CNT_W   = 3;
    localparam int unsigned MSX_M1_WAITS = 1;
    localparam logic [7:0]  VDP_IO_BASE  = 8'h98;
    localparam logic [7:0]  VDP_IO_MASK  = 8'hFC;

endpackage

`default_nettype wire

// File: rtl/wait_down_counter.sv
// ============================================================================
// Module : wait_down_counter
// Loadable saturating down-counter with zero/one flags for wait timing.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module wait_down_counter
    import msx_bus_pkg::*;
#(
    parameter int unsigned WIDTH = WAIT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             is_zero_o,
    output logic             is_one_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_zero_o = (cnt_q == '0);
    assign is_one_o  = (cnt_q == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/z80_wait_gen.sv
// ============================================================================
// Module : z80_wait_gen
// Z80 WAIT_n generator: M1 wait states, optional VDP I/O waits
// (macro Z80_WAIT_IO_WAIT_EN), cartridge wait ANDed in.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module z80_wait_gen
    import msx_bus_pkg::*;
#(
    parameter int unsigned M1_WAITS = MSX_M1_WAITS,
    parameter int unsigned IO_WAITS = 2,
    parameter logic [7:0]  IO_BASE  = VDP_IO_BASE,
    parameter logic [7:0]  IO_MASK  = VDP_IO_MASK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m1_n,
    input  logic       mreq_n,
    input  logic       iorq_n,
    input  logic [7:0] io_addr,
    input  logic       ext_wait_n,
    output logic       wait_n,
    output logic       busy
);

    if ((M1_WAITS > 7) || (IO_WAITS > 7)) begin : g_param_check
        $error("z80_wait_gen: M1_WAITS/IO_WAITS must be in 0..7");
    end

    localparam logic [WAIT_CNT_W-1:0] c_M1_LOAD = WAIT_CNT_W'(M1_WAITS);
    localparam logic [WAIT_CNT_W-1:0] c_IO_LOAD = WAIT_CNT_W'(IO_WAITS);

    wait_state_e               state_q, state_d;
    logic                      int_wait_n_q, int_wait_n_d;
    logic                      w_load;
    logic [WAIT_CNT_W-1:0]     w_load_val;
    logic                      w_cnt_en;
    logic                      w_cnt_zero;
    logic                      w_cnt_one;
    logic                      w_m1_trig;
    logic                      w_io_trig;

    // Interrupt acknowledge (M1 with IORQ) is excluded by both terms.
    assign w_m1_trig = !m1_n && !mreq_n;

`ifdef Z80_WAIT_IO_WAIT_EN
    assign w_io_trig = !iorq_n && m1_n && ((io_addr & IO_MASK) == IO_BASE);
`else
    logic unused_io;
    assign unused_io = ^{io_addr, IO_BASE, IO_MASK};
    assign w_io_trig = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        int_wait_n_d = int_wait_n_q;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_cnt_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_m1_trig) begin
                    if (M1_WAITS > 0) begin
                        w_load       = 1'b1;
                        w_load_val   = c_M1_LOAD;
                        int_wait_n_d = 1'b0;
                        state_d      = WAIT;
                    end else begin
                        state_d      = HOLD;
                    end
                end else if (w_io_trig) begin
                    if (IO_WAITS > 0) begin
                        w_load       = 1'b1;
                        w_load_val   = c_IO_LOAD;
                        int_wait_n_d = 1'b0;
                        state_d      = WAIT;
                    end else begin
                        state_d      = HOLD;
                    end
                end
            end
            WAIT: begin
                w_cnt_en = 1'b1;
                // Count completes even if the strobes were released early.
                if (w_cnt_one || w_cnt_zero) begin
                    int_wait_n_d = 1'b1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (mreq_n && iorq_n) begin
                    state_d = IDLE;
                end
            end
            default: begin
                int_wait_n_d = 1'b1;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            int_wait_n_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            int_wait_n_q <= int_wait_n_d;
        end
    end

    wait_down_counter #(
        .WIDTH (WAIT_CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_load),
        .load_val_i (w_load_val),
        .en_i       (w_cnt_en),
        .is_zero_o  (w_cnt_zero),
        .is_one_o   (w_cnt_one)
    );

    assign wait_n = int_wait_n_q & ext_wait_n;
    assign busy   = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_z80_wait_gen.sv
// ============================================================================
// Module : tb_z80_wait_gen
// Self-checking bench: four generators (M1_WAITS 1/3/5/0) against a model.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_z80_wait_gen;

    localparam int NI = 4;
    localparam int M1N [NI] = '{1, 3, 5, 0};
    localparam int ION = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m1_n = 1'b1;
    logic       mreq_n = 1'b1;
    logic       iorq_n = 1'b1;
    logic [7:0] io_addr = 8'h00;
    logic       ext_wait_n = 1'b1;
    logic [NI-1:0] wait_w;
    logic [NI-1:0] busy_w;

    int vectors = 0;
    int miscompares = 0;

    // Model: remaining low cycles and whether this bus cycle was already served.
    int rem [NI];
    bit served [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        z80_wait_gen #(
            .M1_WAITS (M1N[g]),
            .IO_WAITS (ION),
            .IO_BASE  (8'h98),
            .IO_MASK  (8'hFC)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .m1_n       (m1_n),
            .mreq_n     (mreq_n),
            .iorq_n     (iorq_n),
            .io_addr    (io_addr),
            .ext_wait_n (ext_wait_n),
            .wait_n     (wait_w[g]),
            .busy       (busy_w[g])
        );
    end

    function automatic bit io_hit();
`ifdef Z80_WAIT_IO_WAIT_EN
        return (!iorq_n && m1_n && ((io_addr & 8'hFC) == 8'h98));
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge();
        bit m1t;
        bit iot;
        m1t = !m1_n && !mreq_n;
        iot = io_hit();
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                rem[i] = 0;
                served[i] = 1'b0;
            end else if (rem[i] > 0) begin
                rem[i] = rem[i] - 1;
            end else if (served[i]) begin
                if (mreq_n && iorq_n) served[i] = 1'b0;
            end else if (m1t) begin
                rem[i] = M1N[i];
                served[i] = 1'b1;
            end else if (iot) begin
                rem[i] = ION;
                served[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic exp_w;
        logic exp_b;
        for (int i = 0; i < NI; i++) begin
            exp_w = (rem[i] == 0) & ext_wait_n;
            exp_b = served[i];
            vectors++;
            assert (wait_w[i] === exp_w) else begin
                miscompares++;
                $error("FAIL %s wait_n[M1_WAITS=%0d] observed %b expected %b",
                       tag, M1N[i], wait_w[i], exp_w);
            end
            vectors++;
            assert (busy_w[i] === exp_b) else begin
                miscompares++;
                $error("FAIL %s busy[M1_WAITS=%0d] observed %b expected %b",
                       tag, M1N[i], busy_w[i], exp_b);
            end
        end
    endtask

    task automatic step(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all(tag);
        end
    endtask

    task automatic set_bus(input logic m1, input logic mreq, input logic iorq,
                           input logic [7:0] addr);
        m1_n = m1;
        mreq_n = mreq;
        iorq_n = iorq;
        io_addr = addr;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rem[i] = 0;
            served[i] = 1'b0;
        end
        // Reset with idle bus
        #2;
        rst_n = 1'b0;
        step("reset", 2);
        rst_n = 1'b1;
        step("idle", 1);

        // M1 fetch held 3 cycles, then released
        set_bus(1'b0, 1'b0, 1'b1, 8'h00);
        step("m1_fetch", 3);
        set_bus(1'b1, 1'b1, 1'b1, 8'h00);
        step("m1_release", 3);

        // Early strobe release: count must still complete
        set_bus(1'b0, 1'b0, 1'b1, 8'h00);
        step("early_trig", 1);
        set_bus(1'b1, 1'b1, 1'b1, 8'h00);
        step("early_rel", 7);
        set_bus(1'b0, 1'b0, 1'b1, 8'h00);
        step("retrigger", 4);
        set_bus(1'b1, 1'b1, 1'b1, 8'h00);
        step("retrig_rel", 6);

        // Reset mid-WAIT
        set_bus(1'b0, 1'b0, 1'b1, 8'h00);
        step("midwait_trig", 2);
        rst_n = 1'b0;
        step("midwait_rst", 1);
        rst_n = 1'b1;
        set_bus(1'b1, 1'b1, 1'b1, 8'h00);
        step("after_rst", 2);

        // Interrupt acknowledge, then external wait (combinational path)
        set_bus(1'b0, 1'b1, 1'b0, 8'hFF);
        step("inta", 3);
        ext_wait_n = 1'b0;
        #1;
        check_all("ext_comb");
        step("ext_hold", 2);
        ext_wait_n = 1'b1;
        #1;
        check_all("ext_rel");
        set_bus(1'b1, 1'b1, 1'b1, 8'h00);
        step("inta_rel", 2);

        // I/O to VDP port and to a non-matching port
        set_bus(1'b1, 1'b1, 1'b0, 8'h99);
        step("io_99", 4);
        set_bus(1'b1, 1'b1, 1'b1, 8'h99);
        step("io_99_rel", 2);
        set_bus(1'b1, 1'b1, 1'b0, 8'hA0);
        step("io_A0", 4);
        set_bus(1'b1, 1'b1, 1'b1, 8'hA0);
        step("io_A0_rel", 2);

        // Randomized bus traffic
        for (int k = 0; k < 200; k++) begin
            int kind;
            int len;
            int gap;
            kind = $urandom_range(0, 4);
            len  = $urandom_range(1, 6);
            gap  = $urandom_range(0, 2);
            case (kind)
                0: set_bus(1'b0, 1'b0, 1'b1, 8'($urandom));
                1: set_bus(1'b1, 1'b0, 1'b1, 8'($urandom));
                2: set_bus(1'b1, 1'b1, 1'b0, 8'h98 | 8'($urandom_range(0, 3)));
                3: set_bus(1'b1, 1'b1, 1'b0, 8'($urandom));
                default: set_bus(1'b0, 1'b1, 1'b0, 8'($urandom));
            endcase
            for (int c = 0; c < len; c++) begin
                ext_wait_n = ($urandom_range(0, 4) != 0);
                rst_n = ($urandom_range(0, 60) != 0);
                step("rand_bus", 1);
            end
            set_bus(1'b1, 1'b1, 1'b1, 8'h00);
            for (int c = 0; c < gap; c++) begin
                ext_wait_n = ($urandom_range(0, 4) != 0);
                rst_n = 1'b1;
                step("rand_gap", 1);
            end
        end
        rst_n = 1'b1;
        ext_wait_n = 1'b1;
        set_bus(1'b1, 1'b1, 1'b1, 8'h00);
        step("drain", 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
